// File: rtl/stream_filter_pkg.sv
// rtl/stream_filter_pkg.sv - shared config-bus, host-register and state constants for the stream filter and its feeder
package stream_filter_pkg;

  // Config bus word addresses understood by the filter
  localparam int CFG_WIDTH   = 1;
  localparam int CFG_KERNEL  = 2;
  localparam int CFG_RESCALE = 3;

  // Host register indices
  localparam logic [3:0] REG_WIDTH   = 4'd0;
  localparam logic [3:0] REG_HEIGHT  = 4'd1;
  localparam logic [3:0] REG_SCALE   = 4'd2;
  localparam logic [3:0] REG_KERNEL0 = 4'd3;
  localparam logic [3:0] REG_GAP     = 4'd12;

  localparam int NUM_KERNEL = 9;
  // width word + kernel words + rescale word
  localparam int CFG_WORDS  = NUM_KERNEL + 2;

  // Feeder state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CFG    = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  // Host register index of kernel coefficient i
  function automatic logic [3:0] kernel_reg(input int i);
    return REG_KERNEL0 + 4'(i);
  endfunction

endpackage

// File: rtl/feeder_regs.sv
// rtl/feeder_regs.sv - host register bank for stream_feeder; writes are dropped while a frame is in flight (gap register only with STREAM_FEEDER_LINE_GAP_EN)
module feeder_regs
  import stream_filter_pkg::*;
#(
  parameter int MEM_AWIDTH = 12,
  parameter int KER_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [3:0]                           host_addr,
  input  logic [31:0]                          host_data,
  input  logic                                 host_wr,
  input  logic                                 busy,
  output logic [MEM_AWIDTH-1:0]                width,
  output logic [15:0]                          height,
  output logic [7:0]                           shift,
  output logic [7:0]                           head,
  output logic [NUM_KERNEL-1:0][KER_WIDTH-1:0] kernel
`ifdef STREAM_FEEDER_LINE_GAP_EN
  ,
  output logic [7:0]                           gap
`endif
);

  logic wr_en;
  logic unused_host_bits;

  // The frame in flight must see a stable configuration
  assign wr_en = host_wr & ~busy;

  // Only a slice of each host word is meaningful
  assign unused_host_bits = ^host_data;

  // Register bank: decode the index and capture the relevant slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width  <= '0;
      height <= '0;
      shift  <= '0;
      head   <= '0;
      kernel <= '0;
`ifdef STREAM_FEEDER_LINE_GAP_EN
      gap    <= '0;
`endif
    end else if (wr_en) begin
      if (host_addr == REG_WIDTH) begin
        width <= host_data[MEM_AWIDTH-1:0];
      end
      if (host_addr == REG_HEIGHT) begin
        height <= host_data[15:0];
      end
      if (host_addr == REG_SCALE) begin
        shift <= host_data[15:8];
        head  <= host_data[7:0];
      end
      for (int i = 0; i < NUM_KERNEL; i++) begin
        if (host_addr == kernel_reg(i)) begin
          kernel[i] <= host_data[KER_WIDTH-1:0];
        end
      end
`ifdef STREAM_FEEDER_LINE_GAP_EN
      if (host_addr == REG_GAP) begin
        gap <= host_data[7:0];
      end
`endif
    end
  end

endmodule

// File: rtl/stream_feeder.sv
// rtl/stream_feeder.sv - config sequencer and pixel pump for the stream filter; STREAM_FEEDER_LINE_GAP_EN adds idle gaps between rows
module stream_feeder
  import stream_filter_pkg::*;
#(
  parameter int CFG_DWIDTH   = 32,
  parameter int CFG_AWIDTH   = 5,
  parameter int MEM_AWIDTH   = 12,
  parameter int IMG_WIDTH    = 16,
  parameter int KER_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            host_addr,
  input  logic [31:0]           host_data,
  input  logic                  host_wr,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [IMG_WIDTH-1:0]  up_data,
  input  logic                  up_valid,
  output logic                  up_ready,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic                  cfg_valid,
  output logic [IMG_WIDTH-1:0]  image,
  output logic                  image_val
);

  localparam logic [7:0] CFG_LAST   = 8'(CFG_WORDS - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  logic [MEM_AWIDTH-1:0]                width;
  logic [15:0]                          height;
  logic [7:0]                           shift;
  logic [7:0]                           head;
  logic [NUM_KERNEL-1:0][KER_WIDTH-1:0] kernel;
`ifdef STREAM_FEEDER_LINE_GAP_EN
  logic [7:0]                           gap;
`endif

  logic [2:0]            state;
  // Shared cycle counter: config word index, gap cycles or drain cycles
  logic [7:0]            phase;
  logic [MEM_AWIDTH-1:0] col;
  logic [15:0]           row;

  logic accept;
  logic last_col;
  logic last_row;
  logic empty_frame;
  logic [KER_WIDTH-1:0] ker_word;

  feeder_regs #(
    .MEM_AWIDTH (MEM_AWIDTH),
    .KER_WIDTH  (KER_WIDTH)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_wr   (host_wr),
    .busy      (busy),
    .width     (width),
    .height    (height),
    .shift     (shift),
    .head      (head),
    .kernel    (kernel)
`ifdef STREAM_FEEDER_LINE_GAP_EN
    ,
    .gap       (gap)
`endif
  );

  assign busy        = (state != ST_IDLE);
  assign up_ready    = (state == ST_STREAM);
  assign accept      = up_valid & up_ready;
  assign last_col    = (col == width - MEM_AWIDTH'(1));
  assign last_row    = (row == height - 16'd1);
  assign empty_frame = (width == '0) || (height == '0);
  assign done        = (state == ST_DRAIN) && (phase == DRAIN_LAST);

  // Pick the kernel coefficient for config words 1..9 (k0 first)
  always_comb begin
    ker_word = '0;
    for (int i = 0; i < NUM_KERNEL; i++) begin
      if (phase == 8'(i + 1)) begin
        ker_word = kernel[i];
      end
    end
  end

  // Config bus: one word per CFG cycle, all zero otherwise
  always_comb begin
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    if (state == ST_CFG) begin
      cfg_valid = 1'b1;
      if (phase == 8'd0) begin
        cfg_addr = CFG_AWIDTH'(CFG_WIDTH);
        cfg_data = CFG_DWIDTH'(width);
      end else if (phase <= 8'(NUM_KERNEL)) begin
        cfg_addr = CFG_AWIDTH'(CFG_KERNEL);
        cfg_data = CFG_DWIDTH'(ker_word);
      end else begin
        cfg_addr = CFG_AWIDTH'(CFG_RESCALE);
        cfg_data = CFG_DWIDTH'({shift, head});
      end
    end
  end

  // Frame sequencer: config, stream with column/row tracking, optional row gaps, drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_CFG;
            phase <= '0;
          end
        end
        ST_CFG: begin
          if (phase == CFG_LAST) begin
            phase <= '0;
            col   <= '0;
            row   <= '0;
            state <= empty_frame ? ST_DRAIN : ST_STREAM;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + 16'd1;
              if (last_row) begin
                state <= ST_DRAIN;
                phase <= '0;
              end
`ifdef STREAM_FEEDER_LINE_GAP_EN
              else if (gap != 8'd0) begin
                state <= ST_GAP;
                phase <= '0;
              end
`endif
            end else begin
              col <= col + MEM_AWIDTH'(1);
            end
          end
        end
`ifdef STREAM_FEEDER_LINE_GAP_EN
        ST_GAP: begin
          if (phase == gap - 8'd1) begin
            state <= ST_STREAM;
            phase <= '0;
          end else begin
            phase <= phase + 8'd1;
          end
        end
`endif
        ST_DRAIN: begin
          if (phase == DRAIN_LAST) begin
            state <= ST_IDLE;
            phase <= '0;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          phase <= '0;
        end
      endcase
    end
  end

  // Pixel output register: the filter sees each accepted pixel one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image     <= '0;
      image_val <= 1'b0;
    end else begin
      image_val <= accept;
      image     <= accept ? up_data : '0;
    end
  end

endmodule

// File: tb/tb_stream_feeder.sv
// tb/tb_stream_feeder.sv - randomized self-checking bench for stream_feeder against a frame-level model
module tb_stream_feeder;

  localparam int CFG_DWIDTH = 32;
  localparam int CFG_AWIDTH = 5;
  localparam int MEM_AWIDTH = 12;
  localparam int IMG_WIDTH  = 16;
  localparam int KER_WIDTH  = 16;
  localparam int DRAIN      = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [3:0]            host_addr = '0;
  logic [31:0]           host_data = '0;
  logic                  host_wr = 1'b0;
  logic                  start = 1'b0;
  logic                  busy;
  logic                  done;
  logic [IMG_WIDTH-1:0]  up_data = '0;
  logic                  up_valid = 1'b0;
  logic                  up_ready;
  logic [CFG_DWIDTH-1:0] cfg_data;
  logic [CFG_AWIDTH-1:0] cfg_addr;
  logic                  cfg_valid;
  logic [IMG_WIDTH-1:0]  image;
  logic                  image_val;

  always #5 clk = ~clk;

  stream_feeder #(
    .CFG_DWIDTH   (CFG_DWIDTH),
    .CFG_AWIDTH   (CFG_AWIDTH),
    .MEM_AWIDTH   (MEM_AWIDTH),
    .IMG_WIDTH    (IMG_WIDTH),
    .KER_WIDTH    (KER_WIDTH),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_addr (host_addr),
    .host_data (host_data),
    .host_wr   (host_wr),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .cfg_data  (cfg_data),
    .cfg_addr  (cfg_addr),
    .cfg_valid (cfg_valid),
    .image     (image),
    .image_val (image_val)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: mode 0 idle, 1 config, 2 stream, 3 gap, 4 drain;
  // m_left counts the cycles still to spend in config/gap/drain.
  int          m_mode = 0, m_left = 0, m_acc = 0, m_total = 0;
  int          m_w = 0, m_h = 0, m_sh = 0, m_hd = 0, m_gap = 0;
  int          m_k[9];
  int          m_ca[11];
  logic [31:0] m_cd[11];
  logic        m_pv = 1'b0;
  logic [15:0] m_pd = '0;

  // DUT observations for the literal checks
  logic [31:0] obs_cfg_a[$];
  logic [31:0] obs_cfg_d[$];
  int          obs_cfg_cyc[$];
  logic [15:0] obs_pix[$];
  int          obs_pix_cyc[$];
  int          obs_acc_cyc[$];
  int          done_n = 0, done_cyc = 0, start_cyc = 0;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_acc = 0; m_total = 0;
    m_w = 0; m_h = 0; m_sh = 0; m_hd = 0; m_gap = 0;
    for (int i = 0; i < 9; i++) m_k[i] = 0;
    m_pv = 1'b0; m_pd = '0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    if (a == 4'd0) m_w = int'(d % 4096);
    else if (a == 4'd1) m_h = int'(d & 32'hFFFF);
    else if (a == 4'd2) begin m_sh = int'((d >> 8) & 32'hFF); m_hd = int'(d & 32'hFF); end
    else if (a >= 4'd3 && a <= 4'd11) m_k[int'(a) - 3] = int'(d & 32'hFFFF);
`ifdef STREAM_FEEDER_LINE_GAP_EN
    else if (a == 4'd12) m_gap = int'(d & 32'hFF);
`endif
  endtask

  // Compare every cycle against the model, record observations, then advance the model
  always @(negedge clk) begin : compare
    logic [31:0] ea, ed;
    if (!rst_n) model_reset();
    if (m_mode == 1) begin
      ea = 32'(m_ca[11 - m_left]);
      ed = m_cd[11 - m_left];
    end else begin
      ea = 0;
      ed = 0;
    end
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("cfg_valid", 32'(cfg_valid), 32'(m_mode == 1));
    check("cfg_addr", 32'(cfg_addr), ea);
    check("cfg_data", cfg_data, ed);
    check("up_ready", 32'(up_ready), 32'(m_mode == 2));
    check("image_val", 32'(image_val), 32'(m_pv));
    check("image", 32'(image), m_pv ? 32'(m_pd) : 32'd0);
    check("done", 32'(done), 32'(m_mode == 4 && m_left == 1));

    if (cfg_valid) begin
      obs_cfg_a.push_back(32'(cfg_addr));
      obs_cfg_d.push_back(cfg_data);
      obs_cfg_cyc.push_back(cyc);
    end
    if (image_val) begin
      obs_pix.push_back(image);
      obs_pix_cyc.push_back(cyc);
    end
    if (up_valid && up_ready) obs_acc_cyc.push_back(cyc);
    if (done) begin done_n++; done_cyc = cyc; end
    if (rst_n && start && !busy) start_cyc = cyc;

    if (rst_n) begin
      m_pv = (m_mode == 2) && up_valid;
      m_pd = up_data;
      if (host_wr && m_mode == 0) model_write(host_addr, host_data);
      case (m_mode)
        0: if (start) begin
          m_ca[0] = 1; m_cd[0] = 32'(m_w);
          for (int i = 0; i < 9; i++) begin m_ca[i+1] = 2; m_cd[i+1] = 32'(m_k[i]); end
          m_ca[10] = 3; m_cd[10] = 32'(m_sh * 256 + m_hd);
          m_mode = 1; m_left = 11;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            if (m_w == 0 || m_h == 0) begin m_mode = 4; m_left = DRAIN; end
            else begin m_mode = 2; m_acc = 0; m_total = m_w * m_h; end
          end
        end
        2: if (up_valid) begin
          m_acc++;
          if (m_acc == m_total) begin m_mode = 4; m_left = DRAIN; end
          else if (m_gap != 0 && (m_acc % m_w) == 0) begin m_mode = 3; m_left = m_gap; end
        end
        3: begin m_left--; if (m_left == 0) m_mode = 2; end
        4: begin m_left--; if (m_left == 0) m_mode = 0; end
        default: ;
      endcase
    end
    cyc++;
  end

  // Upstream source
  int          src_mode = 3;
  int          src_idx = 0;
  bit          src_rand = 0;
  bit          vtog = 0;
  logic [15:0] src_pix = '0;

  task automatic drive_src();
    case (src_mode)
      0: up_valid = 1'b1;
      1: begin vtog = !vtog; up_valid = vtog; end
      2: up_valid = 1'($urandom_range(0, 1));
      default: up_valid = 1'b0;
    endcase
    up_data = up_valid ? src_pix : 16'($urandom);
  endtask

  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = up_valid && up_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      src_idx++;
      src_pix = src_rand ? 16'($urandom) : 16'(src_idx);
    end
    drive_src();
  endtask

  task automatic src_reset(input int mode, input bit rnd);
    src_mode = mode; src_rand = rnd; src_idx = 0; vtog = 0;
    src_pix = rnd ? 16'($urandom) : 16'd0;
    drive_src();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    host_addr = a; host_data = d; host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_obs();
    obs_cfg_a.delete(); obs_cfg_d.delete(); obs_cfg_cyc.delete();
    obs_pix.delete(); obs_pix_cyc.delete(); obs_acc_cyc.delete();
  endtask

  task automatic wait_idle(input int bound, input bit noise);
    int n = 0;
    while (busy && n < bound) begin
      if (noise && !done && $urandom_range(0, 3) == 0) begin
        host_wr = 1'b1; host_addr = 4'($urandom); host_data = $urandom;
        start = 1'($urandom_range(0, 1));
      end
      tick();
      host_wr = 1'b0; start = 1'b0;
      n++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", bound);
    end
  endtask

  task automatic wait_accepts(input int count, input int bound);
    int n = 0;
    while (obs_acc_cyc.size() < count && n < bound) begin tick(); n++; end
    check("wait_accepts reached", 32'(obs_acc_cyc.size() >= count), 32'd1);
  endtask

  task automatic check_pixels_in_order(input string tag);
    check({tag, " pixel count"}, 32'(obs_pix.size()), 32'd15);
    if (obs_pix.size() == 15 && obs_acc_cyc.size() == 15) begin
      for (int i = 0; i < 15; i++) begin
        check({tag, " pixel value"}, 32'(obs_pix[i]), 32'(i));
        check({tag, " pixel latency"}, 32'(obs_pix_cyc[i] - obs_acc_cyc[i]), 32'd1);
      end
      check({tag, " done after last accept"}, 32'(done_cyc - obs_acc_cyc[14]), 32'(DRAIN));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset up_ready", 32'(up_ready), 32'd0);
    check("reset cfg_valid", 32'(cfg_valid), 32'd0);
    check("reset image_val", 32'(image_val), 32'd0);

    // Config sequence and full stream: 5x3, always valid, data 0..14
    wr(4'd0, 32'd5); wr(4'd1, 32'd3); wr(4'd2, 32'h0000_0400);
    for (int i = 0; i < 9; i++) wr(4'(3 + i), 32'(i + 1));
    clear_obs();
    src_reset(0, 0);
    pulse_start();
    wait_idle(300, 0);
    check("cfg word count", 32'(obs_cfg_a.size()), 32'd11);
    if (obs_cfg_a.size() == 11) begin
      for (int i = 0; i < 11; i++) begin
        check("cfg addr literal", obs_cfg_a[i], (i == 0) ? 32'd1 : (i == 10) ? 32'd3 : 32'd2);
        check("cfg data literal", obs_cfg_d[i], (i == 0) ? 32'd5 : (i == 10) ? 32'h400 : 32'(i));
        check("cfg consecutive", 32'(obs_cfg_cyc[i] - start_cyc), 32'(i + 1));
      end
    end
    check_pixels_in_order("full");

    // Upstream stalls: valid toggling
    clear_obs();
    src_reset(1, 0);
    pulse_start();
    wait_idle(300, 0);
    check_pixels_in_order("stall");

    // Zero dimension
    wr(4'd1, 32'd0);
    clear_obs();
    src_reset(0, 0);
    pulse_start();
    wait_idle(300, 0);
    check("zero-dim cfg count", 32'(obs_cfg_a.size()), 32'd11);
    check("zero-dim accepts", 32'(obs_acc_cyc.size()), 32'd0);
    check("zero-dim done latency", 32'(done_cyc - start_cyc), 32'(11 + DRAIN));

    // Busy guard: write width=7 and start during STREAM
    wr(4'd1, 32'd3);
    clear_obs();
    src_reset(2, 1);
    d0 = done_n;
    pulse_start();
    wait_accepts(3, 200);
    host_wr = 1'b1; host_addr = 4'd0; host_data = 32'd7; start = 1'b1;
    tick();
    host_wr = 1'b0; start = 1'b0;
    wait_idle(400, 0);
    check("guard accepts", 32'(obs_acc_cyc.size()), 32'd15);
    check("guard single done", 32'(done_n - d0), 32'd1);
    clear_obs();
    src_reset(0, 0);
    pulse_start();
    wait_idle(300, 0);
    check("guard width kept", (obs_cfg_d.size() > 0) ? obs_cfg_d[0] : 32'hDEAD, 32'd5);
    check("guard frame accepts", 32'(obs_acc_cyc.size()), 32'd15);

`ifdef STREAM_FEEDER_LINE_GAP_EN
    // Row gaps of 3 cycles, none after the last row
    wr(4'd12, 32'd3);
    clear_obs();
    src_reset(0, 0);
    pulse_start();
    wait_idle(300, 0);
    if (obs_acc_cyc.size() == 15) begin
      check("gap in-row spacing", 32'(obs_acc_cyc[1] - obs_acc_cyc[0]), 32'd1);
      check("gap row0->1", 32'(obs_acc_cyc[5] - obs_acc_cyc[4]), 32'd4);
      check("gap row1->2", 32'(obs_acc_cyc[10] - obs_acc_cyc[9]), 32'd4);
      check("gap none after last", 32'(done_cyc - obs_acc_cyc[14]), 32'(DRAIN));
    end else begin
      check("gap accepts", 32'(obs_acc_cyc.size()), 32'd15);
    end
    wr(4'd12, 32'd0);
`endif

    // Randomized frames with host noise while busy
    for (int f = 0; f < 8; f++) begin
      wr(4'd0, 32'($urandom_range(0, 6)));
      wr(4'd1, 32'($urandom_range(0, 4)));
      wr(4'd2, $urandom);
      for (int i = 0; i < 9; i++) wr(4'(3 + i), $urandom);
      src_reset(2, 1);
      if ($urandom_range(0, 1) == 1) begin
        host_wr = 1'b1; host_addr = 4'd0; host_data = 32'($urandom_range(1, 6));
      end
      pulse_start();
      host_wr = 1'b0;
      wait_idle(600, 1);
    end

    // Reset mid-stream after pixel 6
    wr(4'd0, 32'd5); wr(4'd1, 32'd3);
    clear_obs();
    src_reset(0, 0);
    d0 = done_n;
    pulse_start();
    wait_accepts(7, 200);
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset up_ready", 32'(up_ready), 32'd0);
    check("midreset image_val", 32'(image_val), 32'd0);
    check("midreset image", 32'(image), 32'd0);
    check("midreset cfg_valid", 32'(cfg_valid), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("midreset no done", 32'(done_n - d0), 32'd0);
    clear_obs();
    src_reset(0, 0);
    pulse_start();
    wait_idle(300, 0);
    check("post-reset cfg count", 32'(obs_cfg_a.size()), 32'd11);
    if (obs_cfg_a.size() == 11) begin
      check("post-reset first addr", obs_cfg_a[0], 32'd1);
      for (int i = 0; i < 11; i++) check("post-reset regs zero", obs_cfg_d[i], 32'd0);
    end
    check("post-reset accepts", 32'(obs_acc_cyc.size()), 32'd0);
    check("post-reset done", 32'(done_n - d0), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
